// File: rtl/key_evt_pkg.sv
// Shared types for the key event scheduler: event codes, per-key FSM state
// encoding and the event-key index width helper.
package key_evt_pkg;

  // Event codes carried on evt_type; 2'b11 is never produced.
  typedef enum logic [1:0] {
    EVT_SHORT  = 2'b00,
    EVT_LONG   = 2'b01,
    EVT_REPEAT = 2'b10
  } evt_type_e;

  // Per-key press classification states.
  typedef enum logic [2:0] {
    StIdle,
    StDeb,
    StPress,
    StHold,
    StRel
  } fsm_state_e;

  // Width of a key index: max(1, clog2(n)).
  function automatic int unsigned key_evt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// One key: 2-flop synchroniser, debounce/classification FSM with a 32-bit
// counter, and a one-entry pending event register.
// Optional: define KEY_REPEAT_EN to post REPEAT events while held after LONG.
module key_event_fsm
  import key_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 15_000_000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      key_raw,    // 0 = pressed, asynchronous
  input  logic      xfer,       // pending entry leaves on this edge
  output logic      key_state,  // debounced, 1 = pressed
  output logic      pend,
  output evt_type_e pend_type,
  output logic      drop
);

  logic [1:0]  sync_q;
  logic        s;
  fsm_state_e  state_q;
  logic [31:0] cnt_q;
  logic        long_seen_q;
  logic        key_state_q;
  logic        pend_q;
  evt_type_e   pend_type_q;
  logic        drop_q;
  logic        deb_hit;
  logic        long_hit;
  logic        post;
  evt_type_e   post_type;

  // Synchronise the raw key; idles high (released) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_raw};
    end
  end

  assign s        = sync_q[1];
  assign deb_hit  = (cnt_q == DEBOUNCE_CYC - 1);
  assign long_hit = (cnt_q == LONG_CYC - 1);

`ifdef KEY_REPEAT_EN
  logic rep_hit;
  assign rep_hit = (cnt_q == REPEAT_CYC - 1);
`else
  logic [31:0] unused_repeat_cyc;
  assign unused_repeat_cyc = REPEAT_CYC;
`endif

  // Decode which event, if any, the FSM posts on this edge.
  always_comb begin
    post      = 1'b0;
    post_type = EVT_SHORT;
    unique case (state_q)
      StPress: begin
        if (!s && long_hit) begin
          post      = 1'b1;
          post_type = EVT_LONG;
        end
      end
      StHold: begin
`ifdef KEY_REPEAT_EN
        if (!s && rep_hit) begin
          post      = 1'b1;
          post_type = EVT_REPEAT;
        end
`endif
      end
      StRel: begin
        // SHORT only for a press that never reached LONG
        if (s && deb_hit && !long_seen_q) begin
          post      = 1'b1;
          post_type = EVT_SHORT;
        end
      end
      default: ;
    endcase
  end

  // Press classification FSM with its counter and debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      long_seen_q <= 1'b0;
      key_state_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!s) state_q <= StDeb;
        end
        StDeb: begin
          if (s) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (deb_hit) begin
            state_q     <= StPress;
            key_state_q <= 1'b1;
            long_seen_q <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StPress: begin
          if (s) begin
            state_q <= StRel;
            cnt_q   <= '0;
          end else if (long_hit) begin
            state_q     <= StHold;
            long_seen_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StHold: begin
          if (s) begin
            state_q <= StRel;
            cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
          end else if (rep_hit) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
`endif
          end
        end
        StRel: begin
          if (!s) begin
            cnt_q <= '0;
          end else if (deb_hit) begin
            state_q     <= StIdle;
            key_state_q <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // One-entry pending slot; a post into a slot that stays full is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_type_q <= EVT_SHORT;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (post) begin
        if (pend_q && !xfer) begin
          drop_q <= 1'b1;
        end else begin
          pend_q      <= 1'b1;
          pend_type_q <= post_type;
        end
      end else if (xfer) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign key_state = key_state_q;
  assign pend      = pend_q;
  assign pend_type = pend_type_q;
  assign drop      = drop_q;

endmodule

// File: rtl/key_event_scheduler.sv
// Multi-key event scheduler: one key_event_fsm per key plus a round-robin
// arbiter feeding a registered valid/ready event port.
// Optional: KEY_REPEAT_EN enables REPEAT events inside each key FSM.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int unsigned KEY_NUM      = 3,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 15_000_000,
  localparam int unsigned KW          = key_evt_width(KEY_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [KW-1:0]      evt_key,
  output logic [1:0]         evt_type,
  output logic               evt_drop
);

  localparam logic [KW:0] KeyNumW = (KW + 1)'(KEY_NUM);

  logic [KEY_NUM-1:0] pend;
  evt_type_e          pend_type [KEY_NUM];
  logic [KEY_NUM-1:0] drop;
  logic [KEY_NUM-1:0] xfer_vec;
  logic [KEY_NUM-1:0] cand;
  logic               xfer;
  logic               valid_q;
  logic [KW-1:0]      key_q;
  evt_type_e          type_q;
  logic [KW-1:0]      ptr_q;
  logic [KW-1:0]      start;
  logic [KW:0]        sum;
  logic               found;
  logic [KW-1:0]      grant_key;
  evt_type_e          grant_type;

  assign xfer = valid_q && evt_ready;

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    assign xfer_vec[k] = xfer && (key_q == KW'(k));

    key_event_fsm #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_raw   (key_in[k]),
      .xfer      (xfer_vec[k]),
      .key_state (key_state[k]),
      .pend      (pend[k]),
      .pend_type (pend_type[k]),
      .drop      (drop[k])
    );
  end

  // Round-robin pick; the entry leaving this edge is excluded and the search
  // starts just past it so back-to-back transfers rotate fairly.
  always_comb begin
    cand       = pend & ~xfer_vec;
    found      = 1'b0;
    grant_key  = '0;
    grant_type = EVT_SHORT;
    sum        = '0;
    if (xfer) begin
      start = (key_q == KW'(KEY_NUM - 1)) ? '0 : key_q + KW'(1);
    end else begin
      start = ptr_q;
    end
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      sum = {1'b0, start} + (KW + 1)'(i);
      if (sum >= KeyNumW) sum = sum - KeyNumW;
      if (!found && cand[sum[KW-1:0]]) begin
        found      = 1'b1;
        grant_key  = sum[KW-1:0];
        grant_type = pend_type[sum[KW-1:0]];
      end
    end
  end

  // Output port registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      type_q  <= EVT_SHORT;
      ptr_q   <= '0;
    end else begin
      if (!valid_q || xfer) begin
        valid_q <= found;
        if (found) begin
          key_q  <= grant_key;
          type_q <= grant_type;
        end
      end
      if (xfer) ptr_q <= start;
    end
  end

  assign evt_valid = valid_q;
  assign evt_key   = key_q;
  assign evt_type  = type_q;
  assign evt_drop  = |drop;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with small timing parameters.
`timescale 1ns/1ps
module tb_key_event_scheduler;
  import key_evt_pkg::*;

`ifdef KEY_REPEAT_EN
  localparam int REP_EN = 1;
`else
  localparam int REP_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_in = 3'b111;
  logic [2:0] key_state;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       evt_drop;

  int unsigned cyc = 0;
  int          checks = 0;
  int          passed = 0;

  logic [1:0]  log_key [$];
  logic [1:0]  log_type [$];
  int unsigned log_cyc [$];
  int unsigned drop_cnt = 0;
  int unsigned rise_cyc [3] = '{0, 0, 0};
  int unsigned rise_cnt [3] = '{0, 0, 0};
  logic [2:0]  ks_prev = 3'b000;

  key_event_scheduler #(
    .KEY_NUM      (3),
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .REPEAT_CYC   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .evt_drop  (evt_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log transfers, drop pulses and key_state rising edges mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready) begin
        log_key.push_back(evt_key);
        log_type.push_back(evt_type);
        log_cyc.push_back(cyc);
      end
      if (evt_drop) drop_cnt <= drop_cnt + 1;
      for (int i = 0; i < 3; i++) begin
        if (key_state[i] && !ks_prev[i]) begin
          rise_cyc[i] <= cyc;
          rise_cnt[i] <= rise_cnt[i] + 1;
        end
      end
    end
    ks_prev <= key_state;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_in = 3'b111;
    evt_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (key_state !== 3'b000) $display("FAIL reset_key_state got %b want 000", key_state); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", evt_valid); else passed++;
    checks++; if (evt_key !== 2'd0) $display("FAIL reset_key got %0d want 0", evt_key); else passed++;
    checks++; if (evt_type !== 2'b00) $display("FAIL reset_type got %b want 00", evt_type); else passed++;
    checks++; if (evt_drop !== 1'b0) $display("FAIL reset_drop got %b want 0", evt_drop); else passed++;
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_short();
    int base;
    do_reset();
    evt_ready = 1'b1;
    base = log_key.size();
    key_in[0] = 1'b0;
    tick(6);
    checks++; if (key_state[0] !== 1'b0) $display("FAIL short_ks_early got %b want 0", key_state[0]); else passed++;
    tick(1);
    checks++; if (key_state[0] !== 1'b1) $display("FAIL short_ks_rise got %b want 1", key_state[0]); else passed++;
    tick(3);
    key_in[0] = 1'b1;
    tick(6);
    checks++; if (key_state[0] !== 1'b1) $display("FAIL short_ks_hold got %b want 1", key_state[0]); else passed++;
    tick(1);
    checks++; if (key_state[0] !== 1'b0) $display("FAIL short_ks_fall got %b want 0", key_state[0]); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL short_valid_early got %b want 0", evt_valid); else passed++;
    tick(1);
    checks++; if (evt_valid !== 1'b1) $display("FAIL short_valid got %b want 1", evt_valid); else passed++;
    tick(10);
    checks++; if (log_key.size() - base !== 1) $display("FAIL short_count got %0d want 1", log_key.size() - base); else passed++;
    if (log_key.size() > base) begin
      checks++; if (log_key[base] !== 2'd0) $display("FAIL short_key got %0d want 0", log_key[base]); else passed++;
      checks++; if (log_type[base] !== EVT_SHORT) $display("FAIL short_type got %b want 00", log_type[base]); else passed++;
    end
  endtask

  task automatic test_long();
    int base;
    int exp_n;
    do_reset();
    evt_ready = 1'b1;
    base = log_key.size();
    exp_n = (REP_EN != 0) ? 5 : 1;
    key_in[1] = 1'b0;
    tick(60);
    key_in[1] = 1'b1;
    tick(20);
    checks++; if (log_key.size() - base !== exp_n) $display("FAIL long_count got %0d want %0d", log_key.size() - base, exp_n); else passed++;
    if (log_key.size() > base) begin
      checks++; if (log_type[base] !== EVT_LONG) $display("FAIL long_type got %b want 01", log_type[base]); else passed++;
      checks++; if (log_key[base] !== 2'd1) $display("FAIL long_key got %0d want 1", log_key[base]); else passed++;
      // posted 20 cycles after the rise, presented one cycle later
      checks++; if (log_cyc[base] - rise_cyc[1] !== 21) $display("FAIL long_delay got %0d want 21", log_cyc[base] - rise_cyc[1]); else passed++;
    end
    for (int j = 1; j < exp_n; j++) begin
      if (log_key.size() > base + j) begin
        checks++; if (log_type[base+j] !== EVT_REPEAT) $display("FAIL repeat_type[%0d] got %b want 10", j, log_type[base+j]); else passed++;
        checks++; if (log_cyc[base+j] - log_cyc[base+j-1] !== 8) $display("FAIL repeat_period[%0d] got %0d want 8", j, log_cyc[base+j] - log_cyc[base+j-1]); else passed++;
      end
    end
    checks++; if (key_state[1] !== 1'b0) $display("FAIL long_ks_released got %b want 0", key_state[1]); else passed++;
  endtask

  task automatic test_glitch();
    int base;
    int unsigned base_rise;
    do_reset();
    evt_ready = 1'b1;
    base = log_key.size();
    base_rise = rise_cnt[2];
    repeat (5) begin
      key_in[2] = 1'b0;
      tick(3);
      key_in[2] = 1'b1;
      tick(2);
    end
    tick(10);
    checks++; if (rise_cnt[2] !== base_rise) $display("FAIL glitch_rise got %0d want %0d", rise_cnt[2], base_rise); else passed++;
    checks++; if (log_key.size() - base !== 0) $display("FAIL glitch_events got %0d want 0", log_key.size() - base); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL glitch_valid got %b want 0", evt_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    evt_ready = 1'b0;
    base = log_key.size();
    key_in = 3'b000;
    tick(10);
    key_in = 3'b111;
    tick(10);
    checks++; if (evt_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", evt_valid); else passed++;
    checks++; if (evt_key !== 2'd0) $display("FAIL b2b_hold_key got %0d want 0", evt_key); else passed++;
    checks++; if (evt_type !== EVT_SHORT) $display("FAIL b2b_hold_type got %b want 00", evt_type); else passed++;
    evt_ready = 1'b1;
    tick(1);
    checks++; if (evt_key !== 2'd1) $display("FAIL b2b_second_key got %0d want 1", evt_key); else passed++;
    tick(1);
    checks++; if (evt_key !== 2'd2) $display("FAIL b2b_third_key got %0d want 2", evt_key); else passed++;
    tick(1);
    checks++; if (evt_valid !== 1'b0) $display("FAIL b2b_drained got %b want 0", evt_valid); else passed++;
    checks++; if (log_key.size() - base !== 3) $display("FAIL b2b_count got %0d want 3", log_key.size() - base); else passed++;
    for (int j = 0; j < 3; j++) begin
      if (log_key.size() > base + j) begin
        checks++; if (log_key[base+j] !== 2'(j)) $display("FAIL b2b_order[%0d] got %0d want %0d", j, log_key[base+j], j); else passed++;
        if (j > 0) begin
          checks++; if (log_cyc[base+j] - log_cyc[base+j-1] !== 1) $display("FAIL b2b_gap[%0d] got %0d want 1", j, log_cyc[base+j] - log_cyc[base+j-1]); else passed++;
        end
      end
    end
  endtask

  task automatic test_drop();
    int base;
    int unsigned base_drop;
    do_reset();
    evt_ready = 1'b0;
    base = log_key.size();
    base_drop = drop_cnt;
    key_in[1] = 1'b0;
    tick(38);
    key_in[1] = 1'b1;
    tick(12);
    checks++; if (drop_cnt - base_drop !== REP_EN) $display("FAIL drop_repeat got %0d want %0d", drop_cnt - base_drop, REP_EN); else passed++;
    checks++; if (evt_valid !== 1'b1) $display("FAIL drop_valid got %b want 1", evt_valid); else passed++;
    checks++; if (evt_type !== EVT_LONG) $display("FAIL drop_kept_type got %b want 01", evt_type); else passed++;
    checks++; if (evt_key !== 2'd1) $display("FAIL drop_kept_key got %0d want 1", evt_key); else passed++;
    // short press: its SHORT lands on the still-full slot
    key_in[1] = 1'b0;
    tick(10);
    key_in[1] = 1'b1;
    tick(12);
    checks++; if (drop_cnt - base_drop !== REP_EN + 1) $display("FAIL drop_short got %0d want %0d", drop_cnt - base_drop, REP_EN + 1); else passed++;
    checks++; if (evt_type !== EVT_LONG) $display("FAIL drop_still_long got %b want 01", evt_type); else passed++;
    evt_ready = 1'b1;
    tick(5);
    checks++; if (log_key.size() - base !== 1) $display("FAIL drop_drain_count got %0d want 1", log_key.size() - base); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL drop_drained got %b want 0", evt_valid); else passed++;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    evt_ready = 1'b0;
    key_in[0] = 1'b0;
    tick(30);
    checks++; if (evt_valid !== 1'b1) $display("FAIL hold_pending got %b want 1", evt_valid); else passed++;
    checks++; if (evt_type !== EVT_LONG) $display("FAIL hold_type got %b want 01", evt_type); else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (key_state !== 3'b000) $display("FAIL midrst_key_state got %b want 000", key_state); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", evt_valid); else passed++;
    checks++; if (evt_type !== 2'b00) $display("FAIL midrst_type got %b want 00", evt_type); else passed++;
    checks++; if (evt_key !== 2'd0) $display("FAIL midrst_key got %0d want 0", evt_key); else passed++;
    checks++; if (evt_drop !== 1'b0) $display("FAIL midrst_drop got %b want 0", evt_drop); else passed++;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    checks++; if (key_state[0] !== 1'b0) $display("FAIL midrst_ks_early got %b want 0", key_state[0]); else passed++;
    tick(1);
    checks++; if (key_state[0] !== 1'b1) $display("FAIL midrst_ks_rise got %b want 1", key_state[0]); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL midrst_no_event got %b want 0", evt_valid); else passed++;
    key_in[0] = 1'b1;
    tick(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_short();
    test_long();
    test_glitch();
    test_back_to_back();
    test_drop();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
